// File: rtl/design3_5_5_core.sv
// Two-stage 32-bit mixing datapath: the input word is registered, then five
// parallel lanes are combined into one hashed word and registered on out.
module design3_5_5_core #(
  parameter logic [31:0] KCONST = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  output logic [31:0] out
);

  logic [31:0] r_in;
  logic [31:0] w_mix;

  function automatic logic [31:0] popcount32(input logic [31:0] word);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, word[i]};
    end
    return {26'd0, cnt};
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] x);
    logic [31:0] l0, l1, l2, l3, l4;
    l0 = x + KCONST;
    l1 = x ^ {x[15:0], x[31:16]};
    l2 = {x[26:0], x[31:27]} | (x >> 3);
    l3 = {16'd0, x[15:0]} * {16'd0, x[31:16]};
    l4 = popcount32(x);
    return ((l0 ^ l1) + (l2 ^ l3)) - l4;
  endfunction

  assign w_mix = mix(r_in);

  // Stage 1: capture the raw input word
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in <= 32'd0;
    end else begin
      r_in <= in;
    end
  end

  // Stage 2: register the mixed result
  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= 32'd0;
    end else begin
      out <= w_mix;
    end
  end

endmodule

// File: tb/tb_design3_5_5_core.sv
// Scoreboard bench for design3_5_5_core: directed words with hand-computed
// results, a mid-stream reset, then a random stream against a reference model.
module tb_design3_5_5_core;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic [31:0] out;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  design3_5_5_core dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_f(input logic [31:0] x);
    logic [31:0] a, b, c, d, pc, rot5, rot16;
    rot16 = (x << 16) | (x >> 16);
    rot5  = (x << 5) | (x >> 27);
    pc = 0;
    for (int i = 0; i < 32; i++) if (x[i]) pc = pc + 1;
    a = x + 32'h9E3779B9;
    b = x ^ rot16;
    c = rot5 | (x >> 3);
    d = 32'(x[15:0]) * 32'(x[31:16]);
    return ((a ^ b) + (c ^ d)) - pc;
  endfunction

  // Drive one edge's inputs and push the value out must hold after that edge.
  task automatic step(input logic rst_v, input logic [31:0] in_v,
                      input logic [31:0] exp_v, input string nm);
    exp_t e;
    @(negedge clk);
    rst = rst_v;
    in  = in_v;
    e.exp  = exp_v;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expected word per edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (out === e.exp) begin
        n_pass++;
      end else begin
        n_fail++;
        $display("FAIL %s: out=%08h expected=%08h", e.name, out, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] w;
    int          guard;
    rst = 1'b0;
    in  = 32'h12345678;

    step(1'b0, 32'h12345678, 32'h00000000, "reset_hold0");
    step(1'b0, 32'h12345678, 32'h00000000, "reset_hold1");
    step(1'b1, 32'h00000000, 32'h9E3779B9, "release_f0");
    step(1'b1, 32'h00000000, 32'h9E3779B9, "release_f0_hold");
    step(1'b1, 32'hFFFFFFFF, 32'h9E3779B9, "stream_lead");
    step(1'b1, 32'h00000001, 32'h9E397996, "f_all_ones");
    step(1'b1, 32'h80000000, 32'h9E3679DA, "f_one");
    step(1'b1, 32'h00000000, 32'hAE37F9C8, "f_msb");
    step(1'b0, 32'hFFFFFFFF, 32'h00000000, "midstream_reset");
    step(1'b1, 32'hDEADBEEF, 32'h9E3779B9, "after_reset_f0");
    step(1'b1, 32'h00000000, ref_f(32'hDEADBEEF), "f_deadbeef");

    prev = 32'h00000000;
    for (int k = 0; k < 1000; k++) begin
      w = $urandom();
      step(1'b1, w, ref_f(prev), "random");
      prev = w;
    end
    step(1'b1, 32'h00000000, ref_f(prev), "random_tail");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
